// File: rtl/myfilter_pkg.sv
// Shared definitions for the filter coefficient memory and its loader.
//   CMEMSIZE            : number of coefficient words held in the scan chain
//   DATABITS            : bits per coefficient word
//   cmem_loader_state_t : loader FSM state encoding (visible on its state_out port)
//   cnt_width()         : width of a counter indexing 0..n-1 (never below 1 bit)
package myfilter_pkg;

  localparam int CMEMSIZE = 4;
  localparam int DATABITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } cmem_loader_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmem_loader_ser.sv
// Parallel-in / serial-out register for one coefficient word.
// The word is loaded in one cycle and then shifted out MSB first, one bit per
// cycle, for DATABITS cycles. A new word may be loaded on the cycle its
// predecessor's last bit is on sd, which makes back-to-back words gapless.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : drop any word in progress and clear the bit counter
//   load      : capture din (takes priority over shifting)
//   shift     : advance one bit while a word is held
//   din       : parallel word in
//   sd        : current serial bit (register MSB)
//   full      : a word is being shifted out (registered)
//   last_bit  : sd carries the final bit of the held word this cycle
module cmem_loader_ser
  import myfilter_pkg::*;
#(
  parameter int DATABITS = myfilter_pkg::DATABITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic                shift,
  input  logic [DATABITS-1:0] din,
  output logic                sd,
  output logic                full,
  output logic                last_bit
);

  localparam int BW = cnt_width(DATABITS);

  logic [DATABITS-1:0] sreg;
  logic [BW-1:0]       bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
    end else if (clr) begin
      sreg    <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
    end else if (load) begin
      sreg    <= din;
      bit_cnt <= '0;
      full    <= 1'b1;
    end else if (shift && full) begin
      // Zero fill, so an emptied register leaves sd low.
      sreg <= {sreg[DATABITS-2:0], 1'b0};
      if (last_bit) begin
        bit_cnt <= '0;
        full    <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  assign sd       = sreg[DATABITS-1];
  assign last_bit = full && (bit_cnt == BW'(DATABITS - 1));

endmodule

// File: rtl/cmem_loader.sv
// Serial loader for the filter coefficient memory scan chain.
// Accepts CMEMSIZE words (CMEMSIZE-1 first) and shifts each MSB first into the
// chain. With CMEM_LOADER_VERIFY_EN defined, a read-back pass then rotates the
// whole chain once (sd_out = sd_in) and compares a checksum of the bits coming
// back against the sum of the loaded words.
//
// Handshake: a word moves when wvalid_in & wready_out are both high at a rising
// edge; wdata_in must be stable while wvalid_in is high; wready_out never
// depends combinationally on wvalid_in.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start_in             : begin a load (taken only in IDLE)
//   wvalid_in/wdata_in   : coefficient word stream
//   wready_out           : word accepted this cycle when wvalid_in is high
//   sde_out, sd_out      : shift enable / serial data to the memory
//   sd_in                : serial data back from the memory (read-back only)
//   busy_out             : load or verify in progress
//   done_out             : one-cycle completion pulse
//   err_out              : checksum mismatch, held until the next start
//   state_out            : current FSM state (debug)
module cmem_loader #(
  parameter int CMEMSIZE = myfilter_pkg::CMEMSIZE,
  parameter int DATABITS = myfilter_pkg::DATABITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_in,
  input  logic                             wvalid_in,
  input  logic [DATABITS-1:0]              wdata_in,
  output logic                             wready_out,
  output logic                             sde_out,
  output logic                             sd_out,
  input  logic                             sd_in,
  output logic                             busy_out,
  output logic                             done_out,
  output logic                             err_out,
  output myfilter_pkg::cmem_loader_state_t state_out
);

  import myfilter_pkg::*;

  localparam int WW = $clog2(CMEMSIZE + 1);

  cmem_loader_state_t state, state_nxt;

  logic [WW-1:0] word_cnt;
  logic          xfer;
  logic          last_word_done;
  logic          ser_clr;
  logic          ser_sd;
  logic          ser_full;
  logic          ser_last_bit;

  assign xfer           = wvalid_in && wready_out;
  assign ser_clr        = (state == IDLE) && start_in;
  // Final bit of the final word is on the chain this cycle.
  assign last_word_done = (state == LOAD) && (word_cnt == WW'(CMEMSIZE)) && ser_last_bit;

  cmem_loader_ser #(
    .DATABITS (DATABITS)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .clr      (ser_clr),
    .load     (xfer),
    .shift    (ser_full),
    .din      (wdata_in),
    .sd       (ser_sd),
    .full     (ser_full),
    .last_bit (ser_last_bit)
  );

`ifdef CMEM_LOADER_VERIFY_EN
  localparam int BW = cnt_width(DATABITS);

  logic [DATABITS-1:0] load_sum;
  logic [DATABITS-1:0] read_sum;
  logic [DATABITS-1:0] rd_shift;
  logic [DATABITS-1:0] rd_word;
  logic [BW-1:0]       vbit;
  logic                verify_end;
  logic                err_q;

  // Word being completed by this cycle's sd_in bit.
  assign rd_word    = {rd_shift[DATABITS-2:0], sd_in};
  assign verify_end = (state == VERIFY) && (word_cnt == WW'(CMEMSIZE - 1))
                      && (vbit == BW'(DATABITS - 1));
  assign err_out    = err_q;
`else
  logic unused_sd_in;
  assign unused_sd_in = sd_in;
  assign err_out      = 1'b0;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_in) state_nxt = LOAD;
      LOAD: begin
        if (last_word_done) begin
`ifdef CMEM_LOADER_VERIFY_EN
          state_nxt = VERIFY;
`else
          state_nxt = DONE;
`endif
        end
      end
      VERIFY: begin
`ifdef CMEM_LOADER_VERIFY_EN
        if (verify_end) state_nxt = DONE;
`else
        state_nxt = DONE;
`endif
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    wready_out = (state == LOAD) && (word_cnt < WW'(CMEMSIZE))
                 && (!ser_full || ser_last_bit);
    busy_out   = (state != IDLE);
    done_out   = (state == DONE);
    sde_out    = ser_full;
    sd_out     = ser_sd;
`ifdef CMEM_LOADER_VERIFY_EN
    if (state == VERIFY) begin
      // Chain rotates through the loader, so it ends up unchanged.
      sde_out = 1'b1;
      sd_out  = sd_in;
    end
`endif
  end

  assign state_out = state;

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
`ifdef CMEM_LOADER_VERIFY_EN
      load_sum <= '0;
      read_sum <= '0;
      rd_shift <= '0;
      vbit     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start_in) begin
            word_cnt <= '0;
`ifdef CMEM_LOADER_VERIFY_EN
            load_sum <= '0;
            read_sum <= '0;
            rd_shift <= '0;
            vbit     <= '0;
            err_q    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (xfer) begin
            word_cnt <= word_cnt + WW'(1);
`ifdef CMEM_LOADER_VERIFY_EN
            load_sum <= load_sum + wdata_in;
`endif
          end
          // Reused as the read-back word counter.
          if (last_word_done) word_cnt <= '0;
        end
`ifdef CMEM_LOADER_VERIFY_EN
        VERIFY: begin
          rd_shift <= rd_word;
          if (vbit == BW'(DATABITS - 1)) begin
            vbit     <= '0;
            read_sum <= read_sum + rd_word;
            word_cnt <= word_cnt + WW'(1);
            if (verify_end) err_q <= ((read_sum + rd_word) != load_sum);
          end else begin
            vbit <= vbit + BW'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmem_loader.sv
// Bench for cmem_loader paired with a behavioural model of the coefficient
// memory scan chain (mem_r[i] = chain[i*DATABITS +: DATABITS], sd_out of the
// memory is the MSB of word CMEMSIZE-1).
module tb_cmem_loader;

  import myfilter_pkg::*;

  localparam int CM = myfilter_pkg::CMEMSIZE;
  localparam int DB = myfilter_pkg::DATABITS;
  localparam int NB = CM * DB;
`ifdef CMEM_LOADER_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic          wvalid_in;
  logic [DB-1:0] wdata_in;
  logic          wready_out;
  logic          sde_out;
  logic          sd_out;
  logic          sd_in;
  logic          busy_out;
  logic          done_out;
  logic          err_out;
  cmem_loader_state_t state_out;

  logic [NB-1:0] chain;
  logic          flip_bit;

  int errors = 0;
  int checks = 0;

  // expected {err, chain} per completed load
  logic [NB:0] exp_q[$];

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  cmem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .wvalid_in  (wvalid_in),
    .wdata_in   (wdata_in),
    .wready_out (wready_out),
    .sde_out    (sde_out),
    .sd_out     (sd_out),
    .sd_in      (sd_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .err_out    (err_out),
    .state_out  (state_out)
  );

  // Coefficient memory scan chain.
  always @(posedge clk) begin
    if (sde_out) chain <= {chain[NB-2:0], sd_out};
  end
  assign sd_in = chain[NB-1] ^ flip_bit;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  // Reference: each accepted word queues DATABITS bits (MSB first) which must
  // appear one per cycle with sde high; read-back holds sde high for
  // CMEMSIZE*DATABITS cycles; DONE is the following cycle.
  int   phase = 0;  // 0 idle, 1 load, 2 read-back, 3 done
  logic bitq[$];
  int   ver_left = 0;
  int   words_seen = 0;
  int   cyc = 0;
  int   first_xfer_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  logic exp_err_sticky = 1'b0;
  bit   first_load_cyc = 1'b0;
  logic e_wr;
  logic [NB:0] e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      phase = 0;
      bitq.delete();
      ver_left = 0;
      words_seen = 0;
      exp_err_sticky = 1'b0;
      first_load_cyc = 1'b0;
    end else begin
      e_wr = (phase == 1) && (words_seen < CM) && (bitq.size() <= 1);
      chk("sde", sde_out, (bitq.size() > 0) || (phase == 2));
      chk("wready", wready_out, e_wr);
      chk("busy", busy_out, phase != 0);
      chk("done", done_out, phase == 3);
      if (bitq.size() > 0) chk("sd_load", sd_out, bitq[0]);
      if (phase == 2) chk("sd_verify", sd_out, sd_in);
      if (phase == 0) chk("err_sticky", err_out, exp_err_sticky);
      if (first_load_cyc) chk("err_clear", err_out, 1'b0);
      first_load_cyc = 1'b0;
      if (phase == 3) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done_out=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          chk("chain", chain, e[NB-1:0]);
          chk("err", err_out, e[NB]);
          exp_err_sticky = e[NB];
        end
        done_cyc = cyc;
        done_cnt++;
      end
      case (phase)
        0: if (start_in) begin
          phase = 1;
          words_seen = 0;
          first_load_cyc = 1'b1;
        end
        1: begin
          if (bitq.size() > 0) void'(bitq.pop_front());
          if (wvalid_in && wready_out) begin
            for (int i = DB - 1; i >= 0; i--) bitq.push_back(wdata_in[i]);
            words_seen++;
            if (words_seen == 1) first_xfer_cyc = cyc;
          end
          if (bitq.size() == 0 && words_seen == CM) begin
            phase = VERIFY_ON ? 2 : 3;
            ver_left = NB;
          end
        end
        2: begin
          ver_left--;
          if (ver_left == 0) phase = 3;
        end
        default: phase = 0;
      endcase
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DB-1:0] w);
    bit got;
    got = 1'b0;
    wvalid_in = 1'b1;
    wdata_in  = w;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = wready_out;
      tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got wready_out=0 for 400 cycles expected 1");
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    @(negedge clk);
    chk({tag, "_wready"}, wready_out, 1'b0);
    chk({tag, "_sde"}, sde_out, 1'b0);
    chk({tag, "_sd"}, sd_out, 1'b0);
    chk({tag, "_busy"}, busy_out, 1'b0);
    chk({tag, "_done"}, done_out, 1'b0);
    chk({tag, "_err"}, err_out, 1'b0);
    chk({tag, "_state"}, state_out, IDLE);
  endtask

  // words: first accepted word in the top DB bits.
  task automatic run_load(input logic [NB-1:0] words, input int gap_idx, input int gap_len,
                          input int rnd_max, input bit start_mid, input bit early_valid,
                          input int flip_at, input int exp_lat);
    logic [NB:0] exp_e;
    int n;
    int d0;
    exp_e = {1'b0, words};
    if (early_valid) begin
      wvalid_in = 1'b1;
      wdata_in  = words[NB-1 -: DB];
    end
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < CM; k++) begin
      send_word(words[NB-1-k*DB -: DB]);
      if (k < CM - 1) begin
        n = (k == gap_idx) ? gap_len : ((rnd_max > 0) ? int'($urandom_range(0, rnd_max)) : 0);
        if (n > 0) wvalid_in = 1'b0;
        for (int g = 0; g < n; g++) begin
          start_in = start_mid && (g == 1);
          tick();
        end
        start_in = 1'b0;
      end
    end
    wvalid_in = 1'b0;
`ifdef CMEM_LOADER_VERIFY_EN
    if (flip_at > 0) begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        seen = (state_out == VERIFY);
      end
      chk("verify_entered", seen, 1'b1);
      tick();
      repeat (flip_at - 1) tick();
      flip_bit = 1'b1;
      tick();
      flip_bit = 1'b0;
      exp_e = {1'b1, words ^ (NB'(1) << (NB - 1 - flip_at))};
    end
`endif
    exp_q.push_back(exp_e);
    d0 = done_cnt;
    for (int i = 0; i < 1000 && done_cnt == d0; i++) tick();
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_out in 1000 cycles expected one");
    end else if (exp_lat >= 0) begin
      chk("latency", done_cyc - first_xfer_cyc, exp_lat + (VERIFY_ON ? NB : 0));
    end
    repeat (2) tick();
  endtask

  function automatic logic [NB-1:0] rand_words();
    logic [NB-1:0] w;
    for (int k = 0; k < CM; k++) w[k*DB +: DB] = DB'($urandom);
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    start_in = 1'b0;
    wvalid_in = 1'b0;
    wdata_in = '0;
    flip_bit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outs("reset");
    tick();

    // Reset held for 3 cycles in the middle of a load.
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    send_word(8'hA5);
    send_word(8'h5A);
    wvalid_in = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outs("midload_reset");
    tick();

    // Gapless directed load.
    run_load(32'h11223344, -1, 0, 0, 1'b0, 1'b0, -1, NB + 1);
    // Valid dropped for 5 ready cycles after word 1, start pulsed while busy.
    run_load(32'h11223344, 1, DB - 1 + 5, 0, 1'b1, 1'b0, -1, NB + 1 + 5);
    run_load(32'hFF01807E, -1, 0, 0, 1'b0, 1'b0, -1, NB + 1);
`ifdef CMEM_LOADER_VERIFY_EN
    // Corrupt one read-back bit; err holds until the next start.
    run_load(32'hFF01807E, -1, 0, 0, 1'b0, 1'b0, 7, NB + 1);
    run_load(rand_words(), -1, 0, 0, 1'b0, 1'b0, -1, NB + 1);
    run_load(rand_words(), -1, 0, 0, 1'b0, 1'b0, 1 + int'($urandom_range(0, NB - 2)), NB + 1);
`endif

    // wvalid_in in IDLE must not move a word.
    wvalid_in = 1'b1;
    wdata_in  = 8'hC3;
    repeat (4) tick();
    // start_in together with wvalid_in.
    run_load({8'hC3, 24'h0F1E2D}, -1, 0, 0, 1'b0, 1'b1, -1, NB + 1);

    for (int r = 0; r < 6; r++) begin
      run_load(rand_words(), -1, 0, 12, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
    end

    repeat (4) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
